alu181_seq: RTL and testbench
=============================

Name: alu181_seq

Overview:
- Parametrised, slice-serial successor to the team's 16-bit 74181-style ALU. It implements the same S[3:0]/M function set over WIDTH bits.
- It processes SLICE bits per clock, chaining the carry through a register.
- It adds a valid/ready handshake on input and output, a registered result, and status flags (C, Z, N, V, AEQB).
- It sits between the register file read ports and the writeback mux of the 16-bit CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH % SLICE must be 0 and SLICE >= 1; any other value is an elaboration error. NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- s  in  4  function select, s[3] MSB.
- m  in  1  1 = logic, 0 = arithmetic.
- cin  in  1  active-high carry in (arithmetic only).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- flags  out  5  {c, z, n, v, aeqb}.

Behaviour:
- Reset: in_ready=1, out_valid=0, y=0, flags=0, state=IDLE, slice counter=0, carry register=0. Reset mid-RUN or mid-DONE aborts the operation and discards it.
- Per-bit terms:
  - X = a | (s0&b) | (s1&~b)
  - Y = (s2&a&~b) | (s3&a&b)
- Arithmetic (m=0): y = X + Y + cin, modulo 2^WIDTH. c = carry out of the MSB.
- Logic (m=1): y = ~(X ^ Y). c = 0, v = 0. Example codes: s=6 gives a^b; s=9 gives ~(a^b); s=11 gives a&b.
- Flags:
  - z = (y == 0).
  - n = y[WIDTH-1].
  - v = arithmetic only: X[msb] == Y[msb] and y[msb] != X[msb].
  - aeqb = (y is all ones).
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b, s, m, cin. Set carry register = cin & ~m, set counter = 0, go to RUN.
  - RUN: in_ready=0. Each cycle compute slice k (bits k*SLICE+SLICE-1 .. k*SLICE) from the latched operands and the carry register. Write that slice of y, update the carry register, increment the counter. After slice NSLICE-1, go to DONE.
  - DONE: out_valid=1, in_ready=out_ready.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: latch the new request and go straight to RUN (back-to-back operation, no bubble).
    - out_ready=0: hold.
- Latency: request accepted at edge 0 gives out_valid=1 after edge NSLICE. Sustained throughput is one operation per NSLICE+1 cycles.
- y and flags change only while in RUN; they are stable whenever out_valid=1. Flags are computed at the transition to DONE.
- SLICE == WIDTH is legal: RUN lasts one cycle.
- Inputs are ignored when the corresponding handshake is not active.

Optional Feature:
- Macro: ALU_CARRY_CHAIN_EN.
- Defined: adds input port chain (1 bit). When chain=1 at accept, the initial carry is the c flag of the previous completed operation instead of cin. This supports multi-precision add/subtract. The stored c is cleared by reset.
- Undefined: the chain port is absent and the initial carry is always cin.

Decomposition:
- Package alu_pkg holds:
  - function-select constants: ALU_S_ADD=4'd9, ALU_S_SUB=4'd6, ALU_S_AND=4'd11, ALU_S_XOR=4'd6 (m=1), ALU_S_PASSA=4'd15 (m=1).
  - flag bit index constants.
  - the state enum (IDLE, RUN, DONE).
- Sub-module alu181_slice: purely combinational SLICE-bit slice (inputs a, b, s, m, cin; outputs f, cout, plus X/Y MSB for overflow). It is instantiated once in alu181_seq.

Test Plan (WIDTH=16, SLICE=4):
- a=0x1234, b=0x0FFF, s=9, m=0, cin=0 -> y=0x2233, c=0, z=0, out_valid rises 4 cycles after accept.
- a=0x0005, b=0x0007, s=6, m=0, cin=1 -> y=0xFFFE, c=0, n=1; then a=0x7FFF, b=0x0001, s=9, cin=0 -> y=0x8000, v=1, n=1.
- a=0xFFFF, b=0x0001, s=9, m=0, cin=0 -> y=0x0000, c=1, z=1; with ALU_CARRY_CHAIN_EN, follow with a=0, b=0, s=9, chain=1 -> y=0x0001.
- a=0xF0F0, b=0xFF00, s=6, m=1 -> y=0x0FF0, c=0, v=0; s=9, m=1 -> y=0xF00F.
- Hold out_ready=0 for 5 cycles in DONE -> y and flags stable, in_ready=0. Then out_ready=1 with in_valid=1 -> next request accepted that cycle, next result after 4 more cycles.
- Assert rst after 2 RUN cycles -> out_valid=0, in_ready=1, y=0 immediately (async). The next operation completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared function-select codes, flag bit positions and FSM states for alu181_seq
package alu_pkg;
    localparam logic [3:0] ALU_S_ADD   = 4'd9;
    localparam logic [3:0] ALU_S_SUB   = 4'd6;
    localparam logic [3:0] ALU_S_AND   = 4'd11;
    localparam logic [3:0] ALU_S_XOR   = 4'd6;
    localparam logic [3:0] ALU_S_PASSA = 4'd15;
    localparam int FLAG_AEQB = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_Z    = 3;
    localparam int FLAG_C    = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/alu181_slice.sv
// alu181_slice: combinational SLICE-bit 74181-style ALU slice
//   a, b     : operand slices
//   s, m     : function select, 1 = logic
//   cin      : carry into the slice
//   f        : slice result
//   cout     : carry out (0 in logic mode)
//   x_msb, y_msb : top bits of the X/Y terms, used for overflow
module alu181_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic [SLICE-1:0] f,
    output logic             cout,
    output logic             x_msb,
    output logic             y_msb
);
    logic [SLICE-1:0] x, yt;
    logic [SLICE:0]   sum;
    assign x     = a | ({SLICE{s[0]}} & b) | ({SLICE{s[1]}} & ~b);
    assign yt    = ({SLICE{s[2]}} & a & ~b) | ({SLICE{s[3]}} & a & b);
    assign sum   = {1'b0, x} + {1'b0, yt} + {{SLICE{1'b0}}, cin};
    assign f     = m ? ~(x ^ yt) : sum[SLICE-1:0];
    assign cout  = ~m & sum[SLICE];
    assign x_msb = x[SLICE-1];
    assign y_msb = yt[SLICE-1];
endmodule

// File: rtl/alu181_seq.sv
// alu181_seq: slice-serial 74181-style ALU with valid/ready handshake and status flags
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake (s, m, cin, a, b sampled on accept)
//   out_valid, out_ready: result handshake (y, flags held while out_valid)
//   flags               : {c, z, n, v, aeqb}
//   ALU_CARRY_CHAIN_EN  : adds input chain; chain=1 seeds the carry with the previous c flag
module alu181_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
`ifdef ALU_CARRY_CHAIN_EN
    input  logic             chain,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [4:0]       flags
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = NSLICE > 1 ? $clog2(NSLICE) : 1;

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_err
        $error("alu181_seq: WIDTH must be a positive multiple of SLICE");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, y_q, y_d;
    logic [3:0]       s_q;
    logic             m_q, carry_q;
    logic [CW-1:0]    cnt_q;
    logic [4:0]       flags_q, flags_d;
    logic [SLICE-1:0] f;
    logic             cout, x_msb, y_msb, accept, last, cin_eff;

    alu181_slice #(.SLICE(SLICE)) u_slice (
        .a(a_q[cnt_q*SLICE +: SLICE]),
        .b(b_q[cnt_q*SLICE +: SLICE]),
        .s(s_q),
        .m(m_q),
        .cin(carry_q),
        .f(f),
        .cout(cout),
        .x_msb(x_msb),
        .y_msb(y_msb)
    );

    assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
    assign out_valid = state_q == DONE;
    assign accept    = in_valid & in_ready;
    assign last      = cnt_q == CW'(NSLICE - 1);
    assign y         = y_q;
    assign flags     = flags_q;
`ifdef ALU_CARRY_CHAIN_EN
    // flags_q still holds the last completed operation's c when a new request is accepted
    assign cin_eff = (chain ? flags_q[FLAG_C] : cin) & ~m;
`else
    assign cin_eff = cin & ~m;
`endif

    // Flags see the full result including the slice being written this cycle;
    // on the last slice the slice MSB is the word MSB.
    always_comb begin
        y_d                     = y_q;
        y_d[cnt_q*SLICE +: SLICE] = f;
        flags_d[FLAG_C]         = ~m_q & cout;
        flags_d[FLAG_Z]         = y_d == '0;
        flags_d[FLAG_N]         = y_d[WIDTH-1];
        flags_d[FLAG_V]         = ~m_q & (x_msb == y_msb) & (y_d[WIDTH-1] != x_msb);
        flags_d[FLAG_AEQB]      = &y_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= cin_eff;
            cnt_q   <= '0;
            state_q <= RUN;
        end else if (state_q == RUN) begin
            y_q     <= y_d;
            carry_q <= cout;
            cnt_q   <= last ? '0 : cnt_q + CW'(1);
            if (last) begin
                flags_q <= flags_d;
                state_q <= DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu181_seq.sv
// tb_alu181_seq: randomized and directed self-checking bench for alu181_seq (WIDTH=16, SLICE=4)
module tb_alu181_seq;
    import alu_pkg::*;
    localparam int W  = 16;
    localparam int NS = 4;
`ifdef ALU_CARRY_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, m = 1'b0, cin = 1'b0;
    logic [3:0]   s = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] y;
    logic [4:0]   flags;
`ifdef ALU_CARRY_CHAIN_EN
    logic         chain = 1'b0;
`endif
    int           errors = 0, checks = 0;
    logic         prev_c = 1'b0;
    logic [W-1:0] got_y;
    logic [4:0]   got_f;

    always #5 clk = ~clk;

    alu181_seq #(.WIDTH(W), .SLICE(NS)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .s(s),
        .m(m),
        .cin(cin),
`ifdef ALU_CARRY_CHAIN_EN
        .chain(chain),
`endif
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y(y),
        .flags(flags)
    );

    // Whole-word reference: 74181 X/Y terms, then plain W-bit arithmetic.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] ts,
                         input logic tm, input logic tc, output logic [W-1:0] ey, output logic [4:0] ef);
        logic [W-1:0] xx, yy;
        logic [W:0]   sum;
        logic         c, v;
        xx = ta | (ts[0] ? tb_ : '0) | (ts[1] ? ~tb_ : '0);
        yy = (ts[2] ? (ta & ~tb_) : '0) | (ts[3] ? (ta & tb_) : '0);
        if (!tm) begin
            sum = {1'b0, xx} + {1'b0, yy} + {{W{1'b0}}, tc};
            ey  = sum[W-1:0];
            c   = sum[W];
            v   = (xx[W-1] == yy[W-1]) && (ey[W-1] != xx[W-1]);
        end else begin
            ey = ~(xx ^ yy);
            c  = 1'b0;
            v  = 1'b0;
        end
        ef = {c, ey == '0, ey[W-1], v, ey == {W{1'b1}}};
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] ts,
                          input logic tm, input logic tc, input logic tch);
        logic [W-1:0] ey;
        logic [4:0]   ef;
        int           cyc;
        model(ta, tb_, ts, tm, (CHAIN_EN && tch) ? prev_c : tc, ey, ef);
        a = ta; b = tb_; s = ts; m = tm; cin = tc; in_valid = 1'b1;
`ifdef ALU_CARRY_CHAIN_EN
        chain = tch;
`endif
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL op_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(cyc);
        checks++;
        if (cyc != NS) begin errors++; $display("FAIL latency: got %0d expected %0d", cyc, NS); end
        checks++;
        if (y !== ey) begin errors++; $display("FAIL y a=%h b=%h s=%0d m=%b: got %h expected %h", ta, tb_, ts, tm, y, ey); end
        checks++;
        if (flags !== ef) begin errors++; $display("FAIL flags a=%h b=%h s=%0d m=%b: got %b expected %b", ta, tb_, ts, tm, flags, ef); end
        got_y  = y;
        got_f  = flags;
        prev_c = ef[4];
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0 || flags !== '0) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b y=%h f=%b expected 1 0 0000 00000", in_ready, out_valid, y, flags);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_arith;
        run_op(16'h1234, 16'h0FFF, ALU_S_ADD, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_y !== 16'h2233 || got_f[4] !== 1'b0 || got_f[3] !== 1'b0) begin errors++; $display("FAIL add: got %h/%b expected 2233 c=0 z=0", got_y, got_f); end
        run_op(16'h0005, 16'h0007, ALU_S_SUB, 1'b0, 1'b1, 1'b0);
        checks++;
        if (got_y !== 16'hFFFE || got_f[4] !== 1'b0 || got_f[2] !== 1'b1) begin errors++; $display("FAIL sub: got %h/%b expected FFFE c=0 n=1", got_y, got_f); end
        run_op(16'h7FFF, 16'h0001, ALU_S_ADD, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_y !== 16'h8000 || got_f[1] !== 1'b1 || got_f[2] !== 1'b1) begin errors++; $display("FAIL ovf: got %h/%b expected 8000 v=1 n=1", got_y, got_f); end
        run_op(16'hFFFF, 16'h0001, ALU_S_ADD, 1'b0, 1'b0, 1'b0);
        checks++;
        if (got_y !== 16'h0000 || got_f[4] !== 1'b1 || got_f[3] !== 1'b1) begin errors++; $display("FAIL wrap: got %h/%b expected 0000 c=1 z=1", got_y, got_f); end
`ifdef ALU_CARRY_CHAIN_EN
        run_op(16'h0000, 16'h0000, ALU_S_ADD, 1'b0, 1'b0, 1'b1);
        checks++;
        if (got_y !== 16'h0001) begin errors++; $display("FAIL chain: got %h expected 0001", got_y); end
`endif
    endtask

    task automatic test_logic;
        run_op(16'hF0F0, 16'hFF00, ALU_S_XOR, 1'b1, 1'b1, 1'b0);
        checks++;
        if (got_y !== 16'h0FF0 || got_f[4] !== 1'b0 || got_f[1] !== 1'b0) begin errors++; $display("FAIL xor: got %h/%b expected 0FF0 c=0 v=0", got_y, got_f); end
        run_op(16'hF0F0, 16'hFF00, 4'd9, 1'b1, 1'b0, 1'b0);
        checks++;
        if (got_y !== 16'hF00F) begin errors++; $display("FAIL xnor: got %h expected F00F", got_y); end
        run_op(16'hF0F0, 16'hFF00, ALU_S_AND, 1'b1, 1'b0, 1'b0);
        checks++;
        if (got_y !== 16'hF000) begin errors++; $display("FAIL and: got %h expected F000", got_y); end
        run_op(16'hFFFF, 16'h1234, ALU_S_PASSA, 1'b1, 1'b0, 1'b0);
        checks++;
        if (got_y !== 16'hFFFF || got_f[0] !== 1'b1) begin errors++; $display("FAIL passa: got %h/%b expected FFFF aeqb=1", got_y, got_f); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ey;
        logic [4:0]   ef;
        int           cyc;
        out_ready = 1'b0;
        model(16'hABCD, 16'h1111, ALU_S_ADD, 1'b0, 1'b0, ey, ef);
        a = 16'hABCD; b = 16'h1111; s = ALU_S_ADD; m = 1'b0; cin = 1'b0; in_valid = 1'b1;
`ifdef ALU_CARRY_CHAIN_EN
        chain = 1'b0;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(cyc);
        prev_c = ef[4];
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || y !== ey || flags !== ef || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold %0d: got vld=%b y=%h f=%b rdy=%b expected 1 %h %b 0", i, out_valid, y, flags, in_ready, ey, ef);
            end
        end
        model(16'h0F0F, 16'h00F1, ALU_S_SUB, 1'b0, 1'b1, ey, ef);
        a = 16'h0F0F; b = 16'h00F1; s = ALU_S_SUB; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: got out_valid=%b expected 0", out_valid); end
        wait_done(cyc);
        checks++;
        if (cyc != NS || y !== ey || flags !== ef) begin
            errors++;
            $display("FAIL b2b_result: got cyc=%0d y=%h f=%b expected %0d %h %b", cyc, y, flags, NS, ey, ef);
        end
        prev_c = ef[4];
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        a = 16'h1234; b = 16'h4321; s = ALU_S_ADD; m = 1'b0; cin = 1'b0; in_valid = 1'b1;
`ifdef ALU_CARRY_CHAIN_EN
        chain = 1'b0;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== '0 || flags !== '0) begin
            errors++;
            $display("FAIL async_rst: got vld=%b rdy=%b y=%h f=%b expected 0 1 0000 00000", out_valid, in_ready, y, flags);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        prev_c = 1'b0;
        run_op(16'h00FF, 16'h0F01, ALU_S_ADD, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++)
            run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
